scalar_lsu: RTL
===============

SCALAR_LSU -- requirements
Module: scalar_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH, sets the data word and lsu_out width.
REQ-002 Parameter ADDRESS_WIDTH, default `DATA_WIDTH, sets the memory address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; when low, state is cleared immediately, independent of clk.
REQ-005 enable  in  1  warp enable; when low, state and outputs hold.
REQ-006 warp_state  in  warp_state_t  current warp pipeline state; WARP_WAIT and WARP_UPDATE are used.
REQ-007 decoded_mem_read_enable  in  1  instruction is a scalar load.
REQ-008 decoded_mem_write_enable  in  1  instruction is a scalar store.
REQ-009 decoded_immediate  in  DATA_WIDTH  signed address offset.
REQ-010 rs1  in  DATA_WIDTH  base address, valid from WARP_WAIT onward.
REQ-011 rs2  in  DATA_WIDTH  store data, valid from WARP_WAIT onward.
REQ-012 mem_read_valid  out  1  read request; mem_read_address  out  ADDRESS_WIDTH.
REQ-013 mem_read_ready  in  1  memory returns read data this cycle; mem_read_data  in  DATA_WIDTH.
REQ-014 mem_write_valid  out  1  write request; mem_write_address  out  ADDRESS_WIDTH; mem_write_data  out  DATA_WIDTH.
REQ-015 mem_write_ready  in  1  memory accepts the write this cycle.
REQ-016 lsu_state  out  2  LSU state encoding: IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
REQ-017 lsu_out  out  DATA_WIDTH  registered load result for the register-file LSU_OUT mux input.

Function
REQ-018 IDLE: when enable and warp_state==WARP_WAIT and either mem enable is high, latch address = (rs1 + decoded_immediate) mod 2^ADDRESS_WIDTH, plus rs2 and the op type, then go to REQUESTING next cycle.
REQ-019 Both read and write enables high is treated as a load; the write is ignored.
REQ-020 Neither enable high: remain in IDLE with no memory request.
REQ-021 REQUESTING: assert the matching *_valid with the latched address (and data for stores) for exactly one cycle, then go to WAITING.
REQ-022 WAITING: hold *_valid and address/data stable until the matching *_ready is sampled high.
REQ-023 A load ready cycle captures mem_read_data into lsu_out, deasserts mem_read_valid, and moves to DONE on the next edge.
REQ-024 A store ready cycle deasserts mem_write_valid and moves to DONE; lsu_out is unchanged.
REQ-025 Ready arriving in the same cycle valid first rises (REQUESTING) is ignored; only ready sampled in WAITING completes the access.
REQ-026 Minimum load latency: state request, +1 REQUESTING, +1 WAITING with ready, +1 DONE; lsu_out is valid from entry into DONE.
REQ-027 DONE: hold lsu_out and issue no request; on warp_state==WARP_UPDATE go to IDLE next cycle.
REQ-028 Ready on the non-matching channel, or any ready in IDLE/DONE, is ignored.
REQ-029 enable low freezes state, outputs and latched operands; enable high resumes from the frozen state.
REQ-030 Only one access is outstanding at a time; a new access starts only from IDLE.

Reset
REQ-031 reset low: lsu_state=IDLE, mem_read_valid=0, mem_write_valid=0, mem_read_address=0, mem_write_address=0, mem_write_data=0, lsu_out=0, all asynchronous.
REQ-032 reset low mid-access in REQUESTING or WAITING aborts the access: valid drops immediately and a later ready is ignored.

Verification
REQ-033 Load: rs1=0x100, imm=0x4, memory ready 3 cycles after valid with data 0xDEADBEEF -> mem_read_address=0x104, valid held stable while waiting, lsu_out=0xDEADBEEF in DONE, IDLE after WARP_UPDATE.
REQ-034 Store: rs1=0x20, imm=-4 (0xFFFFFFFC), rs2=0x55 -> mem_write_address=0x1C, mem_write_data=0x55, DONE after ready, lsu_out unchanged.
REQ-035 Both enables high, rs1=0x8, imm=0 -> only mem_read_valid is asserted, at address 0x8; mem_write_valid stays 0.
REQ-036 Address wrap: rs1=0xFFFFFFFF, imm=2, ADDRESS_WIDTH=32 -> address 0x1.
REQ-037 reset low during WAITING, then ready pulsed -> outputs match REQ-031 immediately and state stays IDLE.
REQ-038 enable low for 5 cycles while WAITING, with ready pulsed during the stall -> no transition; after re-enable, completion requires a new ready.

Source files
------------

// File: rtl/scalar_lsu.sv
// Scalar load/store unit: one outstanding memory access per warp, issued in
// WARP_WAIT, completed on a ready handshake, and released on WARP_UPDATE.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package scalar_lsu_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;
endpackage

module scalar_lsu
  import scalar_lsu_pkg::*;
#(
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  parameter int ADDRESS_WIDTH = `DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  warp_state_t              warp_state,
  input  logic                     decoded_mem_read_enable,
  input  logic                     decoded_mem_write_enable,
  input  logic [DATA_WIDTH-1:0]    decoded_immediate,
  input  logic [DATA_WIDTH-1:0]    rs1,
  input  logic [DATA_WIDTH-1:0]    rs2,
  output logic                     mem_read_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic                     mem_write_ready,
  output logic [1:0]               lsu_state,
  output logic [DATA_WIDTH-1:0]    lsu_out
);

  lsu_state_t               state_r, state_s;
  logic                     is_load_r, is_load_s;
  logic                     read_valid_r, read_valid_s;
  logic                     write_valid_r, write_valid_s;
  logic [ADDRESS_WIDTH-1:0] read_address_r, read_address_s;
  logic [ADDRESS_WIDTH-1:0] write_address_r, write_address_s;
  logic [DATA_WIDTH-1:0]    write_data_r, write_data_s;
  logic [DATA_WIDTH-1:0]    lsu_out_r, lsu_out_s;
  logic [ADDRESS_WIDTH-1:0] effective_address_s;

  // The immediate is signed; the sum wraps modulo the address width.
  assign effective_address_s = ADDRESS_WIDTH'(rs1) + ADDRESS_WIDTH'($signed(decoded_immediate));

  // Next-state and next-output computation; everything holds unless enabled.
  always_comb begin
    state_s         = state_r;
    is_load_s       = is_load_r;
    read_valid_s    = read_valid_r;
    write_valid_s   = write_valid_r;
    read_address_s  = read_address_r;
    write_address_s = write_address_r;
    write_data_s    = write_data_r;
    lsu_out_s       = lsu_out_r;
    if (enable) begin
      case (state_r)
        LSU_IDLE: begin
          if ((warp_state == WARP_WAIT) &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            state_s   = LSU_REQUESTING;
            is_load_s = decoded_mem_read_enable;
            // A load wins when both enables are set.
            if (decoded_mem_read_enable) begin
              read_address_s = effective_address_s;
              read_valid_s   = 1'b1;
            end else begin
              write_address_s = effective_address_s;
              write_data_s    = rs2;
              write_valid_s   = 1'b1;
            end
          end else begin
            state_s = LSU_IDLE;
          end
        end
        LSU_REQUESTING: begin
          state_s = LSU_WAITING;
        end
        LSU_WAITING: begin
          if (is_load_r) begin
            if (mem_read_ready) begin
              lsu_out_s    = mem_read_data;
              read_valid_s = 1'b0;
              state_s      = LSU_DONE;
            end else begin
              state_s = LSU_WAITING;
            end
          end else begin
            if (mem_write_ready) begin
              write_valid_s = 1'b0;
              state_s       = LSU_DONE;
            end else begin
              state_s = LSU_WAITING;
            end
          end
        end
        LSU_DONE: begin
          if (warp_state == WARP_UPDATE) begin
            state_s = LSU_IDLE;
          end else begin
            state_s = LSU_DONE;
          end
        end
        default: begin
          state_s       = LSU_IDLE;
          read_valid_s  = 1'b0;
          write_valid_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= LSU_IDLE;
      is_load_r       <= 1'b0;
      read_valid_r    <= 1'b0;
      write_valid_r   <= 1'b0;
      read_address_r  <= '0;
      write_address_r <= '0;
      write_data_r    <= '0;
      lsu_out_r       <= '0;
    end else begin
      state_r         <= state_s;
      is_load_r       <= is_load_s;
      read_valid_r    <= read_valid_s;
      write_valid_r   <= write_valid_s;
      read_address_r  <= read_address_s;
      write_address_r <= write_address_s;
      write_data_r    <= write_data_s;
      lsu_out_r       <= lsu_out_s;
    end
  end

  assign lsu_state         = state_r;
  assign mem_read_valid    = read_valid_r;
  assign mem_read_address  = read_address_r;
  assign mem_write_valid   = write_valid_r;
  assign mem_write_address = write_address_r;
  assign mem_write_data    = write_data_r;
  assign lsu_out           = lsu_out_r;

endmodule
